// File: rtl/johnson_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
// Shared definitions for the Johnson sequencer:
//   - WIDTH / PHASES  : counter stage count and number of legal codes
//   - state_e         : controller FSM states (IDLE, RUN, DONE)
//   - JC_CODE         : the 8 legal codes in forward order
//   - JC_PHASE        : one-hot phase decode for each legal code
//   - jc_step()       : one shift step, forward or reverse
//   - jc_decode()     : code -> one-hot phase (all-zero for illegal codes)
//   - jc_legal()      : 1 when the code is one of the 8 legal codes
// -----------------------------------------------------------------------------
package johnson_pkg;

   localparam int WIDTH  = 4;
   localparam int PHASES = 2 * WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Index i holds the code at forward position i.
   localparam logic [WIDTH-1:0] JC_CODE [PHASES] = '{
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001
   };

   localparam logic [PHASES-1:0] JC_PHASE [PHASES] = '{
      8'b0000_0001, 8'b0000_0010, 8'b0000_0100, 8'b0000_1000,
      8'b0001_0000, 8'b0010_0000, 8'b0100_0000, 8'b1000_0000
   };

   // Forward shifts the inverted LSB into the MSB; reverse mirrors it.
   function automatic logic [WIDTH-1:0] jc_step(input logic [WIDTH-1:0] cur,
                                                input logic             rev);
      logic [WIDTH-1:0] nxt;
      if (rev) begin
         nxt = {cur[WIDTH-2:0], ~cur[WIDTH-1]};
      end else begin
         nxt = {~cur[0], cur[WIDTH-1:1]};
      end
      return nxt;
   endfunction

   // Phase index is the position in the forward sequence regardless of dir.
   function automatic logic [PHASES-1:0] jc_decode(input logic [WIDTH-1:0] cur);
      logic [PHASES-1:0] ph;
      ph = {PHASES{1'b0}};
      for (int i = 0; i < PHASES; i++) begin
         if (cur == JC_CODE[i]) begin
            ph = JC_PHASE[i];
         end else begin
            ph = ph;
         end
      end
      return ph;
   endfunction

   function automatic logic jc_legal(input logic [WIDTH-1:0] cur);
      return |jc_decode(cur);
   endfunction

endpackage

// File: rtl/johnson_core.sv
// -----------------------------------------------------------------------------
// johnson_core
// Bare Johnson shift register. Steps one position per clock while en is high,
// in the direction selected by dir.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-low reset, loads 0000
//   en  : advance one step this cycle
//   dir : 0 = forward, 1 = reverse
//   q   : current code (registered)
// -----------------------------------------------------------------------------
module johnson_core
   import johnson_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;

   // Shift register; an illegal code (e.g. from an upset) is forced back to
   // 0000 so the counter can never lock into the parasitic cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q_q <= 4'b0000;
      end else if (!jc_legal(q_q)) begin
         q_q <= 4'b0000;
      end else if (en) begin
         q_q <= jc_step(q_q, dir);
      end else begin
         q_q <= q_q;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// -----------------------------------------------------------------------------
// johnson_seq_ctrl
// Run controller around a 4-stage Johnson counter. A run is requested with
// start in IDLE; the counter steps every div+1 cycles while hold is low, and
// the run ends on a revolution boundary (q back to 0000) once run_len
// revolutions are complete or a stop request is pending.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-low reset
//   start   : request a run (IDLE only)
//   stop    : graceful stop request (RUN only, latched)
//   hold    : freeze stepping and prescaler
//   dir     : 0 = forward, 1 = reverse (sampled at start)
//   div     : step period minus one (sampled at start)
//   run_len : revolutions per run, 0 = continuous (sampled at start)
//   q       : Johnson counter value
//   phase   : one-hot phase decode of q
//   busy    : high while in RUN
//   done    : one-cycle pulse in DONE
//   rev_cnt : revolutions completed in current or last run (saturating)
// -----------------------------------------------------------------------------
module johnson_seq_ctrl
   import johnson_pkg::*;
#(
   parameter int WIDTH = johnson_pkg::WIDTH,
   parameter int RUN_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic                hold,
   input  logic                dir,
   input  logic [3:0]          div,
   input  logic [RUN_W-1:0]    run_len,
   output logic [WIDTH-1:0]    q,
   output logic [2*WIDTH-1:0]  phase,
   output logic                busy,
   output logic                done,
   output logic [RUN_W-1:0]    rev_cnt
);

   state_e             state_q, state_d;
   logic [3:0]         presc_q, presc_d;
   logic [RUN_W-1:0]   rev_q, rev_d;
   logic               stop_pend_q, stop_pend_d;
   logic               dir_q, dir_d;
   logic [3:0]         div_q, div_d;
   logic [RUN_W-1:0]   len_q, len_d;

   logic [WIDTH-1:0]   q_s;
   logic               step_s;
   logic               rev_edge_s;
   logic [RUN_W-1:0]   rev_inc_s;
   logic               len_hit_s;

   johnson_core u_core (
      .clk (clk),
      .rst (rst),
      .en  (step_s),
      .dir (dir_q),
      .q   (q_s)
   );

   // Step strobe, revolution detection and saturating revolution count.
   always_comb begin
      step_s     = (state_q == ST_RUN) && !hold && (presc_q == div_q);
      rev_edge_s = step_s && (jc_step(q_s, dir_q) == 4'b0000);
      if (rev_q == {RUN_W{1'b1}}) begin
         rev_inc_s = rev_q;
      end else begin
         rev_inc_s = rev_q + {{(RUN_W-1){1'b0}}, 1'b1};
      end
      len_hit_s  = (len_q != {RUN_W{1'b0}}) && (rev_inc_s == len_q);
   end

   // FSM next-state, prescaler, stop latch and run-parameter capture.
   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      rev_d       = rev_q;
      stop_pend_d = stop_pend_q;
      dir_d       = dir_q;
      div_d       = div_q;
      len_d       = len_q;

      case (state_q)
         ST_IDLE: begin
            // A stop arriving together with start is dropped.
            stop_pend_d = 1'b0;
            if (start) begin
               dir_d   = dir;
               div_d   = div;
               len_d   = run_len;
               presc_d = 4'd0;
               rev_d   = {RUN_W{1'b0}};
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            // Stop is latched even while hold freezes stepping.
            if (stop) begin
               stop_pend_d = 1'b1;
            end else begin
               stop_pend_d = stop_pend_q;
            end

            if (hold) begin
               presc_d = presc_q;
            end else if (presc_q == div_q) begin
               presc_d = 4'd0;
            end else begin
               presc_d = presc_q + 4'd1;
            end

            // Runs only end on a revolution boundary so q is always 0000
            // when DONE is reached.
            if (rev_edge_s) begin
               rev_d = rev_inc_s;
               if (len_hit_s || stop_pend_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end

         ST_DONE: begin
            stop_pend_d = 1'b0;
            state_d     = ST_IDLE;
         end

         default: begin
            stop_pend_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         presc_q     <= 4'd0;
         rev_q       <= {RUN_W{1'b0}};
         stop_pend_q <= 1'b0;
         dir_q       <= 1'b0;
         div_q       <= 4'd0;
         len_q       <= {RUN_W{1'b0}};
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         rev_q       <= rev_d;
         stop_pend_q <= stop_pend_d;
         dir_q       <= dir_d;
         div_q       <= div_d;
         len_q       <= len_d;
      end
   end

   assign q       = q_s;
   assign phase   = jc_decode(q_s);
   assign busy    = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign rev_cnt = rev_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_johnson_seq_ctrl
// Directed bench for johnson_seq_ctrl: a vector table for the reverse and
// hold runs, plus hand-written sequences for the multi-cycle cases. Inputs
// are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_johnson_seq_ctrl;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic       start   = 1'b0;
   logic       stop    = 1'b0;
   logic       hold    = 1'b0;
   logic       dir     = 1'b0;
   logic [3:0] div     = 4'd0;
   logic [7:0] run_len = 8'd0;
   logic [3:0] q;
   logic [7:0] phase;
   logic       busy;
   logic       done;
   logic [7:0] rev_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   johnson_seq_ctrl #(.WIDTH(4), .RUN_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .stop    (stop),
      .hold    (hold),
      .dir     (dir),
      .div     (div),
      .run_len (run_len),
      .q       (q),
      .phase   (phase),
      .busy    (busy),
      .done    (done),
      .rev_cnt (rev_cnt)
   );

   always #5 clk = ~clk;

   localparam logic [3:0] FWD [8] = '{
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001
   };

   typedef struct {
      logic       st;
      logic       sp;
      logic       hd;
      logic       dr;
      logic [3:0] dv;
      logic [7:0] ln;
      logic [3:0] eq;
      logic [7:0] eph;
      logic       eb;
      logic       ed;
      logic [7:0] er;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic st, input logic sp, input logic hd,
                               input logic dr, input logic [3:0] dv,
                               input logic [7:0] ln, input logic [3:0] eq,
                               input logic [7:0] eph, input logic eb,
                               input logic ed, input logic [7:0] er);
      vec_t v;
      v.st = st; v.sp = sp; v.hd = hd; v.dr = dr; v.dv = dv; v.ln = ln;
      v.eq = eq; v.eph = eph; v.eb = eb; v.ed = ed; v.er = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clr_inputs();
      start = 1'b0; stop = 1'b0; hold = 1'b0; dir = 1'b0;
      div = 4'd0; run_len = 8'd0;
   endtask

   // Wait (bounded) for q to reach a code; result reported as a comparison.
   task automatic wait_q(input logic [3:0] code, input string name);
      logic found;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (q == code) found = 1'b1;
      end
      chk(name, found, 1);
   endtask

   // Count falling edges until done is seen (bounded at 40).
   task automatic count_to_done(output int cnt);
      cnt = 1;
      @(negedge clk);
      while (!done && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int dpulses;

      // Reverse run, run_len=1.
      vt.push_back(mk(1,0,0,1,4'd0,8'd1, 4'b0000,8'h01,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b0001,8'h80,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b0011,8'h40,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b0111,8'h20,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b1111,8'h10,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b1110,8'h08,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b1100,8'h04,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b1000,8'h02,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b0000,8'h01,0,1,8'd1));
      // start during DONE is ignored
      vt.push_back(mk(1,1,0,0,4'd0,8'd0, 4'b0000,8'h01,0,0,8'd1));
      // Forward run, run_len=1, hold 5 cycles at 1100.
      vt.push_back(mk(1,0,0,0,4'd0,8'd1, 4'b0000,8'h01,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b1000,8'h02,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b1100,8'h04,1,0,8'd0));
      vt.push_back(mk(0,0,1,0,4'd0,8'd0, 4'b1100,8'h04,1,0,8'd0));
      vt.push_back(mk(1,0,1,1,4'd5,8'd9, 4'b1100,8'h04,1,0,8'd0));
      vt.push_back(mk(0,0,1,0,4'd0,8'd0, 4'b1100,8'h04,1,0,8'd0));
      vt.push_back(mk(0,0,1,0,4'd0,8'd0, 4'b1100,8'h04,1,0,8'd0));
      vt.push_back(mk(0,0,1,0,4'd0,8'd0, 4'b1100,8'h04,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b1110,8'h08,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b1111,8'h10,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b0111,8'h20,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b0011,8'h40,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b0001,8'h80,1,0,8'd0));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b0000,8'h01,0,1,8'd1));
      vt.push_back(mk(0,0,0,0,4'd0,8'd0, 4'b0000,8'h01,0,0,8'd1));

      // Reset state, with start asserted to show reset dominates.
      start = 1'b1; run_len = 8'd3;
      repeat (3) @(negedge clk);
      chk("rst_q", q, 4'b0000);
      chk("rst_phase", phase, 8'h01);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rev", rev_cnt, 8'd0);
      clr_inputs();
      rst = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      // Table-driven vectors.
      foreach (vt[i]) begin
         start = vt[i].st; stop = vt[i].sp; hold = vt[i].hd;
         dir = vt[i].dr; div = vt[i].dv; run_len = vt[i].ln;
         @(negedge clk);
         chk($sformatf("vec%0d_q", i), q, vt[i].eq);
         chk($sformatf("vec%0d_phase", i), phase, vt[i].eph);
         chk($sformatf("vec%0d_busy", i), busy, vt[i].eb);
         chk($sformatf("vec%0d_done", i), done, vt[i].ed);
         chk($sformatf("vec%0d_rev", i), rev_cnt, vt[i].er);
      end
      clr_inputs();

      // Forward run, run_len=2, div=0: done 16 clocks after busy rises.
      start = 1'b1; run_len = 8'd2;
      @(negedge clk);
      clr_inputs();
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("fwd%0d_q", k), q, FWD[k % 8]);
         chk($sformatf("fwd%0d_phase", k), phase, 8'b1 << (k % 8));
         chk($sformatf("fwd%0d_busy", k), busy, 1);
         chk($sformatf("fwd%0d_done", k), done, 0);
      end
      @(negedge clk);
      chk("fwd_end_done", done, 1);
      chk("fwd_end_busy", busy, 0);
      chk("fwd_end_rev", rev_cnt, 8'd2);
      chk("fwd_end_q", q, 4'b0000);
      @(negedge clk);
      chk("fwd_after_done", done, 0);
      chk("fwd_after_busy", busy, 0);
      chk("fwd_after_rev", rev_cnt, 8'd2);

      // div=2, run_len=1: each code held 3 cycles, done 24 clocks later.
      start = 1'b1; div = 4'd2; run_len = 8'd1;
      @(negedge clk);
      clr_inputs();
      for (int k = 0; k < 24; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("div%0d_q", k), q, FWD[k / 3]);
         chk($sformatf("div%0d_done", k), done, 0);
      end
      @(negedge clk);
      chk("div_end_done", done, 1);
      chk("div_end_rev", rev_cnt, 8'd1);
      @(negedge clk);

      // Continuous run stopped at 1110: finishes the revolution.
      start = 1'b1; run_len = 8'd0;
      @(negedge clk);
      clr_inputs();
      wait_q(4'b1110, "stop_wait_1110");
      stop = 1'b1;
      count_to_done(cnt);
      stop = 1'b0;
      chk("stop_cycles", cnt, 5);
      chk("stop_done_q", q, 4'b0000);
      chk("stop_rev", rev_cnt, 8'd1);
      chk("stop_busy", busy, 0);
      @(negedge clk);
      chk("stop_after_done", done, 0);

      // Stop while held: same outcome once hold drops.
      start = 1'b1; run_len = 8'd0;
      @(negedge clk);
      clr_inputs();
      wait_q(4'b1110, "hstop_wait_1110");
      hold = 1'b1; stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("hstop_frozen0", q, 4'b1110);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("hstop_frozen%0d", k), q, 4'b1110);
         chk($sformatf("hstop_busy%0d", k), busy, 1);
      end
      hold = 1'b0;
      count_to_done(cnt);
      chk("hstop_cycles", cnt, 5);
      chk("hstop_q", q, 4'b0000);
      chk("hstop_rev", rev_cnt, 8'd1);
      @(negedge clk);

      // start+stop together in IDLE starts a run; stop is dropped.
      start = 1'b1; stop = 1'b1; run_len = 8'd0;
      @(negedge clk);
      clr_inputs();
      chk("ss_busy", busy, 1);
      repeat (8) @(negedge clk);
      chk("ss_rev1_q", q, 4'b0000);
      chk("ss_rev1_busy", busy, 1);
      chk("ss_rev1_done", done, 0);
      chk("ss_rev1_cnt", rev_cnt, 8'd1);
      repeat (4) @(negedge clk);
      chk("abort_at_1111", q, 4'b1111);

      // Reset for one edge mid-run: no done pulse.
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("abort_q", q, 4'b0000);
      chk("abort_phase", phase, 8'h01);
      chk("abort_busy", busy, 0);
      chk("abort_rev", rev_cnt, 8'd0);
      chk("abort_done", done, 0);
      dpulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done || busy) dpulses++;
      end
      chk("abort_no_done", dpulses, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
